// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory arbiter: FSM state and requester side encodings.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_side_t;

    function automatic arb_side_t other_side(input arb_side_t side);
        if (side == ARB_I) begin
            return ARB_D;
        end else begin
            return ARB_I;
        end
    endfunction

endpackage

// File: rtl/cache_arbiter_arb_select.sv
// Combinational requester picker: fixed D-over-I priority, or round-robin when
// CACHE_ARB_ROUND_ROBIN_EN is defined.
module arb_select
    import rv32i_types::*;
(
    input  logic      i_req_i,
    input  logic      d_req_i,
    input  arb_side_t last_served_i,
    output logic      grant_valid_o,
    output arb_side_t grant_side_o
);

`ifndef CACHE_ARB_ROUND_ROBIN_EN
    logic unused_last_s;
    assign unused_last_s = last_served_i;
`endif

    // pick which side wins the next grant
    always_comb begin
        grant_valid_o = i_req_i | d_req_i;
        grant_side_o  = ARB_I;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        if (i_req_i && d_req_i) begin
            grant_side_o = other_side(last_served_i);
        end else if (d_req_i) begin
            grant_side_o = ARB_D;
        end else begin
            grant_side_o = ARB_I;
        end
`else
        if (d_req_i) begin
            grant_side_o = ARB_D;
        end else begin
            grant_side_o = ARB_I;
        end
`endif
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the single memory line port between I-cache and D-cache miss paths.
// Optional round-robin selection via CACHE_ARB_ROUND_ROBIN_EN (default: D-over-I priority).
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_read,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [LINE_WIDTH-1:0] inst_rdata,
    output logic                  inst_resp,
    input  logic                  data_read,
    input  logic                  data_write,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [LINE_WIDTH-1:0] data_wdata,
    output logic [LINE_WIDTH-1:0] data_rdata,
    output logic                  data_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t            state_q, state_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic      grant_valid_s;
    arb_side_t grant_side_s;
    arb_side_t last_served_s;
    logic      resp_valid_s;
    arb_side_t resp_side_s;

    arb_select u_arb_select (
        .i_req_i       (inst_read),
        .d_req_i       (data_read | data_write),
        .last_served_i (last_served_s),
        .grant_valid_o (grant_valid_s),
        .grant_side_o  (grant_side_s)
    );

    // next-state, command latch and zero-latency response generation
    always_comb begin
        state_d      = state_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_resp    = 1'b0;
        data_resp    = 1'b0;
        resp_valid_s = 1'b0;
        resp_side_s  = ARB_I;
        case (state_q)
            IDLE: begin
                if (grant_valid_s && (grant_side_s == ARB_D)) begin
                    // a simultaneous read+write is illegal; the write-back takes precedence
                    mem_read_d  = data_read & ~data_write;
                    mem_write_d = data_write;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                    state_d     = GRANT_D;
                end else if (grant_valid_s) begin
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = inst_addr;
                    state_d     = GRANT_I;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_I: begin
                if (mem_resp) begin
                    inst_resp    = 1'b1;
                    resp_valid_s = 1'b1;
                    resp_side_s  = ARB_I;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    state_d      = DONE;
                end else begin
                    state_d = GRANT_I;
                end
            end
            GRANT_D: begin
                if (mem_resp) begin
                    data_resp    = 1'b1;
                    resp_valid_s = 1'b1;
                    resp_side_s  = ARB_D;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    state_d      = DONE;
                end else begin
                    state_d = GRANT_D;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // state and registered memory command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q <= {LINE_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    arb_side_t last_served_q;

    // remember which side completed most recently
    always_ff @(posedge clk) begin
        if (rst) begin
            last_served_q <= ARB_I;
        end else if (resp_valid_s) begin
            last_served_q <= resp_side_s;
        end else begin
            last_served_q <= last_served_q;
        end
    end

    assign last_served_s = last_served_q;
`else
    logic unused_resp_s;
    assign unused_resp_s = resp_valid_s ^ resp_side_s;
    assign last_served_s = ARB_I;
`endif

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vector table, corner sequences and
// randomized transactions checked against a transaction-level arbitration model.
module tb_cache_arbiter;

    logic         clk;
    logic         rst;
    logic         inst_read;
    logic [31:0]  inst_addr;
    logic [255:0] inst_rdata;
    logic         inst_resp;
    logic         data_read;
    logic         data_write;
    logic [31:0]  data_addr;
    logic [255:0] data_wdata;
    logic [255:0] data_rdata;
    logic         data_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    int n_cmp = 0;
    int n_err = 0;
    logic model_last_d = 1'b0;

    cache_arbiter #(.LINE_WIDTH(256), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_read  (inst_read),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_resp  (inst_resp),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_resp  (data_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ir, dr, dw;
        logic [31:0]  ia, da;
        logic [255:0] wd;
        int           lat;
        logic [255:0] line;
        logic         exp_d, exp_rd, exp_wr;
        logic [31:0]  exp_addr;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic ir, dr, dw, input logic [31:0] ia, da,
                                input logic [255:0] wd, input int lat, input logic [255:0] line,
                                input logic exp_d, exp_rd, exp_wr, input logic [31:0] exp_addr);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.wd = wd;
        v.lat = lat; v.line = line;
        v.exp_d = exp_d; v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_addr = exp_addr;
        return v;
    endfunction

    // arbitration rule: returns 1 when D should win
    function automatic logic pick_d(input logic ir, input logic dreq, input logic last_d);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        if (ir && dreq) return !last_d;
`endif
        return dreq;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        inst_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
        inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 256'h0;
        mem_resp = 1'b0; mem_rdata = 256'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 256'h0);
        chk("rst_resp", {inst_resp, data_resp}, 2'b00);
        rst = 1'b0;
        model_last_d = 1'b0;
    endtask

    // one full transaction from IDLE: request, grant, wait, resp, DONE, back to IDLE
    task automatic run_txn(input logic ir, dr, dw, input logic [31:0] ia, da,
                           input logic [255:0] wd, input int lat, input logic [255:0] line,
                           input logic keep, input logic exp_d, exp_rd, exp_wr,
                           input logic [31:0] exp_addr);
        inst_read = ir; data_read = dr; data_write = dw;
        inst_addr = ia; data_addr = da; data_wdata = wd; mem_resp = 1'b0;
        step();
        chk("cmd_read", mem_read, exp_rd);
        chk("cmd_write", mem_write, exp_wr);
        chk("cmd_addr", mem_addr, exp_addr);
        if (exp_wr) chk("cmd_wdata", mem_wdata, wd);
        inst_addr = $urandom; data_addr = $urandom; data_wdata = {8{$urandom}};
        for (int k = 0; k < lat; k++) begin
            #1;
            chk("early_resp", {inst_resp, data_resp}, 2'b00);
            step();
            chk("hold_addr", mem_addr, exp_addr);
            chk("hold_cmd", {mem_read, mem_write}, {exp_rd, exp_wr});
        end
        mem_rdata = line;
        mem_resp = 1'b1;
        #1;
        chk("inst_resp", inst_resp, !exp_d);
        chk("data_resp", data_resp, exp_d);
        chk("inst_rdata", inst_rdata, line);
        chk("data_rdata", data_rdata, line);
        step();
        mem_resp = 1'($urandom_range(0, 1));
        if (!keep) begin
            if (exp_d) begin
                data_read = 1'b0; data_write = 1'b0;
            end else begin
                inst_read = 1'b0;
            end
        end
        #1;
        chk("done_cmd", {mem_read, mem_write}, 2'b00);
        chk("done_resp", {inst_resp, data_resp}, 2'b00);
        step();
        mem_resp = 1'b0;
        chk("idle_cmd", {mem_read, mem_write}, 2'b00);
        model_last_d = exp_d;
    endtask

    // expected grant derived from the arbitration model
    task automatic model_txn(input logic ir, dr, dw, input logic [31:0] ia, da,
                             input logic [255:0] wd, input int lat, input logic keep);
        logic d_wins;
        d_wins = pick_d(ir, dr | dw, model_last_d);
        run_txn(ir, dr, dw, ia, da, wd, lat, {8{$urandom}}, keep, d_wins,
                d_wins ? (dr & ~dw) : 1'b1, d_wins & dw, d_wins ? da : ia);
    endtask

    initial begin
        logic [255:0] dead;
        logic [255:0] ones;
        int           pat;
        int           kind;
        logic         ir, dr, dw;
        dead = {16{16'hDEAD}};
        ones = {256{1'b1}};
        clk_wait_init: begin end
        vecs[0] = mk(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, 256'h0, 3, {32{8'hA5}}, 1'b0, 1'b1, 1'b0, 32'h60);
        vecs[1] = mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h200, dead, 1, {32{8'h3C}}, 1'b1, 1'b0, 1'b1, 32'h200);
        vecs[2] = mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h340, 256'h0, 0, {32{8'h5A}}, 1'b1, 1'b1, 1'b0, 32'h340);
        vecs[3] = mk(1'b0, 1'b1, 1'b1, 32'h0, 32'h480, {8{32'h1234_5678}}, 2, 256'h1, 1'b1, 1'b0, 1'b1, 32'h480);
        vecs[4] = mk(1'b1, 1'b0, 1'b0, 32'hFFFF_FFE0, 32'h0, 256'h0, 4, ones, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFE0);
        vecs[5] = mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, ones, 2, 256'h0, 1'b1, 1'b0, 1'b1, 32'h0);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].ia, vecs[i].da, vecs[i].wd,
                    vecs[i].lat, vecs[i].line, 1'b0, vecs[i].exp_d, vecs[i].exp_rd,
                    vecs[i].exp_wr, vecs[i].exp_addr);
        end

        // simultaneous I read + D write after reset: D first, then the held I request
        do_reset();
        run_txn(1'b1, 1'b0, 1'b1, 32'h100, 32'h200, dead, 2, {32{8'h11}}, 1'b0,
                1'b1, 1'b0, 1'b1, 32'h200);
        run_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 256'h0, 1, {32{8'h22}}, 1'b0,
                1'b0, 1'b1, 1'b0, 32'h100);

        // both sides held continuously for four transactions
        do_reset();
        for (int t = 0; t < 4; t++) begin
            model_txn(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(t * 32), 32'h2000 + 32'(t * 32),
                      256'h0, 1, 1'b1);
        end

        // reset one cycle into a D-side grant abandons it
        do_reset();
        data_write = 1'b1; data_addr = 32'h200; data_wdata = {16{16'hBEEF}};
        step();
        chk("rg_cmd_write", mem_write, 1'b1);
        step();
        chk("rg_still_write", mem_write, 1'b1);
        rst = 1'b1;
        data_write = 1'b0;
        step();
        chk("rg_write_cleared", mem_write, 1'b0);
        chk("rg_addr_cleared", mem_addr, 32'h0);
        chk("rg_wdata_cleared", mem_wdata, 256'h0);
        rst = 1'b0;
        model_last_d = 1'b0;
        mem_resp = 1'b1;
        #1;
        chk("rg_no_resp", {inst_resp, data_resp}, 2'b00);
        step();
        mem_resp = 1'b0;
        chk("rg_idle_cmd", {mem_read, mem_write}, 2'b00);
        run_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 256'h0, 1, {32{8'h77}}, 1'b0,
                1'b0, 1'b1, 1'b0, 32'h300);

        // spurious mem_resp in IDLE is ignored
        mem_rdata = {8{$urandom}};
        mem_resp = 1'b1;
        #1;
        chk("spur_resp", {inst_resp, data_resp}, 2'b00);
        step();
        mem_resp = 1'b0;
        chk("spur_cmd", {mem_read, mem_write}, 2'b00);
        run_txn(1'b1, 1'b0, 1'b0, 32'h3E0, 32'h0, 256'h0, 1, {32{8'h99}}, 1'b0,
                1'b0, 1'b1, 1'b0, 32'h3E0);

        // randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            pat  = int'($urandom_range(0, 2));
            kind = int'($urandom_range(0, 7));
            ir = (pat != 1);
            dr = 1'b0;
            dw = 1'b0;
            if (pat != 0) begin
                if (kind == 0) begin
                    dr = 1'b1; dw = 1'b1;
                end else if (kind < 4) begin
                    dr = 1'b1;
                end else begin
                    dw = 1'b1;
                end
            end
            model_txn(ir, dr, dw, $urandom & 32'hFFFF_FFE0, $urandom & 32'hFFFF_FFE0,
                      {8{$urandom}}, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                inst_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
                mem_resp = 1'b1;
                #1;
                chk("rand_spur_resp", {inst_resp, data_resp}, 2'b00);
                step();
                mem_resp = 1'b0;
                chk("rand_spur_cmd", {mem_read, mem_write}, 2'b00);
            end
        end

        clear_inputs();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
